// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write/retire port, optional write-to-read
// bypass and a per-register pending-write scoreboard that decode uses to stall on RAW hazards.
module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int NREGS    = 32,
    parameter int CNT_W    = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             busy1,
    output logic             busy2,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_addr,
    output logic             iss_ready,
    output logic             any_pending
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] rf_r  [NREGS];
    logic [CNT_W-1:0] cnt_r [NREGS];

    logic [CNT_W-1:0] cnt_ra1_s, cnt_ra2_s, cnt_wa3_s, cnt_iss_s;
    logic             retire_s;
    logic [NREGS-1:0] wr_vec_s, inc_vec_s, dec_vec_s;

    // Registers that exist and hold state: out-of-range addresses and a hardwired r0 are ignored.
    function automatic logic tracked_f(input logic [AW-1:0] a);
        logic in_range;
        in_range  = (32'(a) < 32'(NREGS));
        tracked_f = in_range && !((ZERO_REG != 0) && (a == {AW{1'b0}}));
    endfunction

    // Counter lookups, zero for untracked addresses so no out-of-range index reaches the outputs.
    always_comb begin
        cnt_ra1_s = {CNT_W{1'b0}};
        cnt_ra2_s = {CNT_W{1'b0}};
        cnt_wa3_s = {CNT_W{1'b0}};
        cnt_iss_s = {CNT_W{1'b0}};
        if (tracked_f(ra1)) cnt_ra1_s = cnt_r[ra1]; else cnt_ra1_s = {CNT_W{1'b0}};
        if (tracked_f(ra2)) cnt_ra2_s = cnt_r[ra2]; else cnt_ra2_s = {CNT_W{1'b0}};
        if (tracked_f(wa3)) cnt_wa3_s = cnt_r[wa3]; else cnt_wa3_s = {CNT_W{1'b0}};
        if (tracked_f(iss_addr)) cnt_iss_s = cnt_r[iss_addr]; else cnt_iss_s = {CNT_W{1'b0}};
        retire_s = we3 && (cnt_wa3_s != {CNT_W{1'b0}});
    end

    // A full counter blocks a new issue unless the same register retires this cycle.
    always_comb begin
        iss_ready = 1'b1;
        if ((cnt_iss_s == CNT_MAX) && !(retire_s && (wa3 == iss_addr))) begin
            iss_ready = 1'b0;
        end else begin
            iss_ready = 1'b1;
        end
    end

    // One-hot write, issue and retire decode per register.
    always_comb begin
        wr_vec_s  = {NREGS{1'b0}};
        inc_vec_s = {NREGS{1'b0}};
        dec_vec_s = {NREGS{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            wr_vec_s[i]  = we3 && tracked_f(wa3) && (wa3 == AW'(i));
            dec_vec_s[i] = wr_vec_s[i] && (cnt_r[i] != {CNT_W{1'b0}});
            inc_vec_s[i] = iss_valid && iss_ready && tracked_f(iss_addr) && (iss_addr == AW'(i));
        end
    end

    // Register storage and scoreboard counters; a simultaneous issue and retire cancel out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_r[i]  <= {WIDTH{1'b0}};
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_vec_s[i]) rf_r[i] <= wd3;
                else             rf_r[i] <= rf_r[i];
                if (inc_vec_s[i] && !dec_vec_s[i])      cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                else if (dec_vec_s[i] && !inc_vec_s[i]) cnt_r[i] <= cnt_r[i] - CNT_W'(1);
                else                                    cnt_r[i] <= cnt_r[i];
            end
        end
    end

    // Read ports; forced to zero while reset is held so a bypassed write cannot leak out.
    always_comb begin
        rd1 = {WIDTH{1'b0}};
        rd2 = {WIDTH{1'b0}};
        if (!reset_n || !tracked_f(ra1))            rd1 = {WIDTH{1'b0}};
        else if ((BYPASS != 0) && we3 && wa3 == ra1) rd1 = wd3;
        else                                          rd1 = rf_r[ra1];
        if (!reset_n || !tracked_f(ra2))            rd2 = {WIDTH{1'b0}};
        else if ((BYPASS != 0) && we3 && wa3 == ra2) rd2 = wd3;
        else                                          rd2 = rf_r[ra2];
    end

    // A single pending write clears busy early only when its retire is being bypassed right now.
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        if (cnt_ra1_s > CNT_W'(1))      busy1 = 1'b1;
        else if (cnt_ra1_s == CNT_W'(1)) busy1 = !((BYPASS != 0) && retire_s && (wa3 == ra1));
        else                             busy1 = 1'b0;
        if (cnt_ra2_s > CNT_W'(1))      busy2 = 1'b1;
        else if (cnt_ra2_s == CNT_W'(1)) busy2 = !((BYPASS != 0) && retire_s && (wa3 == ra2));
        else                             busy2 = 1'b0;
    end

    // Pending flag reflects the counters as they stand, not their next value.
    always_comb begin
        any_pending = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            any_pending = any_pending | (cnt_r[i] != {CNT_W{1'b0}});
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector bench for regfile_sb with default parameters (32x32, CNT_W=2, bypass, hardwired r0).
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  ra1, ra2, wa3, iss_addr;
    logic [31:0] rd1, rd2, wd3;
    logic        busy1, busy2, we3, iss_valid, iss_ready, any_pending;
    logic [67:0] obs_s;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        we3;
        logic [4:0]  wa3;
        logic [31:0] wd3;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        iv;
        logic [4:0]  ia;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
        logic        e_rdy;
        logic        e_ap;
    } vec_t;

    vec_t vecs [17];

    regfile_sb dut (
        .clk(clk), .reset_n(reset_n),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .any_pending(any_pending)
    );

    always #5 clk = ~clk;

    assign obs_s = {rd1, rd2, busy1, busy2, iss_ready, any_pending};

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got {rd1,rd2,b1,b2,rdy,ap}=%h expected %h", name, act, exp);
    endtask

    task automatic idle();
        we3 = 1'b0; wa3 = 5'd0; wd3 = 32'd0;
        iss_valid = 1'b0; iss_addr = 5'd0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 5'd0, 32'h1234,     5'd0, 5'd5, 1'b0, 5'd0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd5, 1'b1, 5'd7, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b1, 5'd7, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd5, 1'b1, 5'd7, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd5, 1'b1, 5'd7, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 5'd7, 32'h11111111, 5'd7, 5'd7, 1'b1, 5'd7, 32'h11111111, 32'h11111111, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd5, 1'b0, 5'd7, 32'h11111111, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7, 1'b0, 5'd7, 32'h22222222, 32'h22222222, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 5'd7, 32'h33333333, 5'd7, 5'd5, 1'b0, 5'd7, 32'h33333333, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 5'd7, 32'h44444444, 5'd7, 5'd8, 1'b0, 5'd7, 32'h44444444, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd8, 1'b0, 5'd7, 32'h44444444, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9, 1'b0, 5'd0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd7, 1'b0, 5'd0, 32'hA5A5A5A5, 32'h44444444, 1'b0, 1'b0, 1'b1, 1'b0};

        // Held in reset with active write/issue traffic: outputs stay clear, events are lost.
        reset_n = 1'b0;
        we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hFFFFFFFF;
        ra1 = 5'd5; ra2 = 5'd0; iss_valid = 1'b1; iss_addr = 5'd5;
        @(negedge clk); #1;
        check("reset_hold", obs_s, {32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
        @(negedge clk); #1;
        check("reset_hold2", obs_s, {32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
        idle();
        reset_n = 1'b1;

        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            ra1 = 5'(a); ra2 = 5'(31 - a);
            #1;
            check($sformatf("post_reset_addr%0d", a), obs_s, {32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
        end

        for (int v = 0; v < 17; v++) begin
            @(negedge clk);
            we3 = vecs[v].we3; wa3 = vecs[v].wa3; wd3 = vecs[v].wd3;
            ra1 = vecs[v].ra1; ra2 = vecs[v].ra2;
            iss_valid = vecs[v].iv; iss_addr = vecs[v].ia;
            #1;
            check($sformatf("vec%0d", v), obs_s,
                  {vecs[v].e_rd1, vecs[v].e_rd2, vecs[v].e_b1, vecs[v].e_b2, vecs[v].e_rdy, vecs[v].e_ap});
        end

        // Mid-cycle asynchronous reset with live data and a pending counter.
        @(negedge clk);
        idle();
        iss_valid = 1'b1; iss_addr = 5'd3;
        @(negedge clk);
        idle();
        iss_addr = 5'd3; ra1 = 5'd9; ra2 = 5'd3;
        #1;
        check("pre_async_reset", obs_s, {32'hA5A5A5A5, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1});
        #1;
        reset_n = 1'b0;
        we3 = 1'b1; wa3 = 5'd9; wd3 = 32'hFFFFFFFF;
        #1;
        check("async_reset_clear", obs_s, {32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
        #1;
        idle();
        iss_addr = 5'd3;
        reset_n = 1'b1;
        @(negedge clk); #1;
        check("after_reset_r9", obs_s, {32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
        ra1 = 5'd5; ra2 = 5'd7;
        #1;
        check("after_reset_r5_r7", obs_s, {32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
